// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: default widths, queued-entry struct,
// write-port source select and the one-hot destination helper.
package wb_pkg;

  localparam int unsigned RAWIDTH = 5;
  localparam int unsigned DWIDTH  = 32;

  typedef struct packed {
    logic [RAWIDTH-1:0] rd;
    logic [DWIDTH-1:0]  data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_LSU
  } wb_src_t;

  // x0 is never a real destination, so it maps to an empty mask.
  function automatic logic [2**RAWIDTH-1:0] onehot_rd(input logic [RAWIDTH-1:0] rd);
    onehot_rd = '0;
    if (rd != '0) onehot_rd[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU result, long-latency handshake, register file write port
// and hazard/occupancy status. The arbiter uses the slave modport.
interface wb_arbiter_if #(
  parameter int unsigned RAWIDTH = wb_pkg::RAWIDTH,
  parameter int unsigned DWIDTH  = wb_pkg::DWIDTH,
  parameter int unsigned DEPTH   = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                  alu_valid;
  logic [RAWIDTH-1:0]    alu_rd;
  logic [DWIDTH-1:0]     alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [RAWIDTH-1:0]    lsu_rd;
  logic [DWIDTH-1:0]     lsu_data;
  logic                  RegWEn;
  logic [RAWIDTH-1:0]    AddrD;
  logic [DWIDTH-1:0]     DataD;
  logic [2**RAWIDTH-1:0] pending_mask;
  logic [CW-1:0]         fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready, RegWEn, AddrD, DataD, pending_mask, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output lsu_ready, RegWEn, AddrD, DataD, pending_mask, fifo_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Long-latency result queue. Exposes every slot and its valid bit so the
// arbiter can build the pending-write mask.
module wb_fifo import wb_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = wb_entry_t,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  entry_t           din,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output entry_t           entries [DEPTH],
  output logic [DEPTH-1:0] valid
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register file write-port driver: ALU first, then queued long-latency results.
// Optional WB_BYPASS_EN lets an accepted result skip an empty, idle queue.
module wb_arbiter import wb_pkg::*; #(
  parameter int unsigned RAWIDTH = wb_pkg::RAWIDTH,
  parameter int unsigned DWIDTH  = wb_pkg::DWIDTH,
  parameter int unsigned DEPTH   = 4
) (
  input logic        clk,
  input logic        rst,
  wb_arbiter_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [RAWIDTH-1:0] rd;
    logic [DWIDTH-1:0]  data;
  } entry_t;

  entry_t                head;
  entry_t                din;
  entry_t                entries [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic                  full;
  logic                  empty;
  logic [AW:0]           count;
  logic                  alu_live;
  logic                  lsu_live;
  logic                  push;
  logic                  pop;
  wb_src_t               src;
  logic                  reg_wen;
  logic [RAWIDTH-1:0]    reg_addr;
  logic [DWIDTH-1:0]     reg_data;
  logic [2**RAWIDTH-1:0] mask;

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     (din),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .entries (entries),
    .valid   (valid)
  );

  // Writes to x0 are dropped at the source, so they never occupy the port.
  always_comb begin
    alu_live = bus.alu_valid && (bus.alu_rd != '0);
    lsu_live = bus.lsu_valid && !full && (bus.lsu_rd != '0);
    din      = '{rd: bus.lsu_rd, data: bus.lsu_data};
    src      = SRC_NONE;
    if (alu_live)    src = SRC_ALU;
    else if (!empty) src = SRC_FIFO;
`ifdef WB_BYPASS_EN
    else if (lsu_live) src = SRC_LSU;
`endif
    pop  = (src == SRC_FIFO);
    push = lsu_live && (src != SRC_LSU);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wen  <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
    end else begin
      case (src)
        SRC_ALU: begin
          reg_wen  <= 1'b1;
          reg_addr <= bus.alu_rd;
          reg_data <= bus.alu_data;
        end
        SRC_FIFO: begin
          reg_wen  <= 1'b1;
          reg_addr <= head.rd;
          reg_data <= head.data;
        end
        SRC_LSU: begin
          reg_wen  <= 1'b1;
          reg_addr <= bus.lsu_rd;
          reg_data <= bus.lsu_data;
        end
        default: reg_wen <= 1'b0;
      endcase
    end
  end

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i]) mask[entries[i].rd] = 1'b1;
    end
    if (reg_wen) mask[reg_addr] = 1'b1;
    mask[0] = 1'b0;
  end

  assign bus.lsu_ready    = !full;
  assign bus.fifo_count   = count;
  assign bus.RegWEn       = reg_wen;
  assign bus.AddrD        = reg_addr;
  assign bus.DataD        = reg_data;
  assign bus.pending_mask = mask;

endmodule
